cdb_arbiter: RTL and testbench

Common Data Bus arbiter/broadcaster. It collects completed results from the functional units, buffers them in small per-FU FIFOs, and drives one registered `CDB_PACKET`-style broadcast per cycle. The broadcast carries a ROB tag and a value, and is consumed by the reservation stations, ROB and map table. It is the producing end of the CDB that the reservation stations snoop for tag wakeup.

---
 rtl/cdb_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Common Data Bus arbiter/broadcaster. Completed results from NUM_FU functional
// units are buffered in small per-FU circular FIFOs. Each cycle one non-empty
// FIFO is granted in round-robin order, and its head is driven onto a
// registered CDB broadcast {valid, rob_tag, value}.
//
// Handshake: an FU result is taken on a rising edge where
// fu_valid[i] && fu_ready[i]. The FU holds its result until then.
// fu_ready[i] depends only on the registered FIFO count, so it has no
// combinational path from fu_valid, arbitration or squash. The CDB side has
// no backpressure: each broadcast is held for exactly one cycle.
//
// Ports:
//   clock        in   single clock
//   reset        in   synchronous active-low reset
//   squash       in   flush: clears FIFOs, output register and rr pointer
//   fu_valid     in   [NUM_FU]         FU i presents a completed result
//   fu_rob_tag   in   [NUM_FU][TAG_W]  ROB tag of that result (0 = illegal)
//   fu_value     in   [NUM_FU][XLEN]   result value
//   fu_ready     out  [NUM_FU]         FIFO i can accept this cycle
//   cdb_valid    out  broadcast valid
//   cdb_rob_tag  out  broadcast tag (0 when not valid)
//   cdb_v        out  broadcast value (0 when not valid)
//   dbg_rr_ptr   out  current round-robin pointer, for observation only
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_FU = 5,
   parameter int DEPTH  = 2,
   parameter int TAG_W  = 5,
   parameter int XLEN   = 32,
   localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         squash,
   input  logic [NUM_FU-1:0]            fu_valid,
   input  logic [NUM_FU-1:0][TAG_W-1:0] fu_rob_tag,
   input  logic [NUM_FU-1:0][XLEN-1:0]  fu_value,
   output logic [NUM_FU-1:0]            fu_ready,
   output logic                         cdb_valid,
   output logic [TAG_W-1:0]             cdb_rob_tag,
   output logic [XLEN-1:0]              cdb_v,
   output logic [RR_W-1:0]              dbg_rr_ptr
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int SCAN_W = RR_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
   localparam logic [RR_W-1:0]  LAST_FU   = RR_W'(NUM_FU - 1);

   // FIFO storage (no reset needed: only entries below count are ever read)
   logic [TAG_W-1:0] tag_mem_q [NUM_FU][DEPTH];
   logic [XLEN-1:0]  val_mem_q [NUM_FU][DEPTH];

   logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
   logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
   logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
   logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
   logic [CNT_W-1:0] cnt_q    [NUM_FU];
   logic [CNT_W-1:0] cnt_d    [NUM_FU];

   logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic             cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0] cdb_tag_q,   cdb_tag_d;
   logic [XLEN-1:0]  cdb_v_q,     cdb_v_d;

   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] pop;
   logic [NUM_FU-1:0] nonempty;

   logic              grant_vld;
   logic [RR_W-1:0]   grant_idx;
   logic [SCAN_W-1:0] scan_idx;
   logic [RR_W-1:0]   scan_cand;

   function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + 1'b1;
   endfunction

   // Ready and occupancy come from registered counts only. A zero-tag result
   // still sees ready (the FU is released) but is never written.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         fu_ready[i] = (cnt_q[i] < DEPTH_C);
         nonempty[i] = (cnt_q[i] != '0);
         push[i]     = fu_valid[i] && fu_ready[i] && (fu_rob_tag[i] != '0);
      end
   end

   // Round-robin scan starting at rr_ptr_q, first non-empty FIFO wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      scan_cand = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + SCAN_W'(k);
         if (scan_idx >= SCAN_W'(NUM_FU)) begin
            scan_idx = scan_idx - SCAN_W'(NUM_FU);
         end
         scan_cand = scan_idx[RR_W-1:0];
         if (!grant_vld && nonempty[scan_cand]) begin
            grant_vld = 1'b1;
            grant_idx = scan_cand;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         pop[i] = grant_vld && (grant_idx == RR_W'(i));
      end
   end

   // Next state. Squash overrides push, pop and grant.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = '0;
      cdb_v_d     = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         cnt_d[i]    = cnt_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
      end

      if (squash) begin
         rr_ptr_d = '0;
         for (int i = 0; i < NUM_FU; i++) begin
            cnt_d[i]    = '0;
            rd_ptr_d[i] = '0;
            wr_ptr_d[i] = '0;
         end
      end else begin
         if (grant_vld) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_mem_q[grant_idx][rd_ptr_q[grant_idx]];
            cdb_v_d     = val_mem_q[grant_idx][rd_ptr_q[grant_idx]];
            rr_ptr_d    = (grant_idx == LAST_FU) ? '0 : grant_idx + 1'b1;
         end
         for (int i = 0; i < NUM_FU; i++) begin
            if (pop[i]) begin
               rd_ptr_d[i] = next_slot(rd_ptr_q[i]);
            end
            if (push[i]) begin
               wr_ptr_d[i] = next_slot(wr_ptr_q[i]);
            end
            // Push and pop together leave the count unchanged.
            case ({push[i], pop[i]})
               2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
               2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
               default: cnt_d[i] = cnt_q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_v_q     <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            cnt_q[i]    <= '0;
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_v_q     <= cdb_v_d;
         for (int i = 0; i < NUM_FU; i++) begin
            cnt_q[i]    <= cnt_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (push[i] && !squash && reset) begin
            tag_mem_q[i][wr_ptr_q[i]] <= fu_rob_tag[i];
            val_mem_q[i][wr_ptr_q[i]] <= fu_value[i];
         end
      end
   end

   // Tag 0 means "no producer"; an FU handing one in is a protocol error.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (reset && fu_valid[i] && fu_ready[i]) begin
            assert (fu_rob_tag[i] != '0)
               else $warning("cdb_arbiter: zero ROB tag from FU %0d discarded", i);
         end
      end
   end

   assign cdb_valid   = cdb_valid_q;
   assign cdb_rob_tag = cdb_tag_q;
   assign cdb_v       = cdb_v_q;
   assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

   localparam int NUM_FU = 5;
   localparam int DEPTH  = 2;
   localparam int TAG_W  = 5;
   localparam int XLEN   = 32;
   localparam int RR_W   = 3;
   localparam int ENT_W  = TAG_W + XLEN;

   // ---------------- clock / reset / DUT ----------------
   logic                         clock = 1'b0;
   logic                         reset;
   logic                         squash;
   logic [NUM_FU-1:0]            fu_valid;
   logic [NUM_FU-1:0][TAG_W-1:0] fu_rob_tag;
   logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
   logic [NUM_FU-1:0]            fu_ready;
   logic                         cdb_valid;
   logic [TAG_W-1:0]             cdb_rob_tag;
   logic [XLEN-1:0]              cdb_v;
   logic [RR_W-1:0]              dbg_rr_ptr;

   always #5 clock = ~clock;

   cdb_arbiter #(
      .NUM_FU (NUM_FU),
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W),
      .XLEN   (XLEN)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .squash      (squash),
      .fu_valid    (fu_valid),
      .fu_rob_tag  (fu_rob_tag),
      .fu_value    (fu_value),
      .fu_ready    (fu_ready),
      .cdb_valid   (cdb_valid),
      .cdb_rob_tag (cdb_rob_tag),
      .cdb_v       (cdb_v),
      .dbg_rr_ptr  (dbg_rr_ptr)
   );

   // ---------------- reference model / scoreboard ----------------
   logic [ENT_W-1:0]  exp_q [NUM_FU][$];  // what each FIFO should hold, in order
   logic [ENT_W-1:0]  src_q [NUM_FU][$];  // results each FU still has to hand over
   logic [TAG_W-1:0]  seen_q[$];          // tags observed on the CDB
   int                rr_m;
   logic              exp_valid;
   logic [TAG_W-1:0]  exp_tag;
   logic [XLEN-1:0]   exp_v;
   logic [NUM_FU-1:0] exp_ready;
   logic [NUM_FU-1:0] ready_seen;
   logic [NUM_FU-1:0] accepted;
   int                checks;
   int                errors;

   function automatic int pending();
      int n;
      n = 0;
      for (int i = 0; i < NUM_FU; i++) n += exp_q[i].size() + src_q[i].size();
      return n;
   endfunction

   // ---------------- driver: one clock of FU traffic + model update ----------------
   task automatic run_cycle();
      int               g;
      int               idx;
      logic             sq;
      logic             rs;
      logic [ENT_W-1:0] ent;
      for (int i = 0; i < NUM_FU; i++) begin
         fu_valid[i]   = (src_q[i].size() > 0);
         ent           = fu_valid[i] ? src_q[i][0] : '0;
         fu_rob_tag[i] = ent[ENT_W-1:XLEN];
         fu_value[i]   = ent[XLEN-1:0];
      end
      #1;
      ready_seen = fu_ready;
      for (int i = 0; i < NUM_FU; i++) exp_ready[i] = (exp_q[i].size() < DEPTH);
      accepted = fu_valid & exp_ready;
      g = -1;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = (rr_m + k) % NUM_FU;
         if (g < 0 && exp_q[idx].size() != 0) g = idx;
      end
      sq = squash;
      rs = reset;
      @(posedge clock);
      #1;
      if (!rs || sq) begin
         for (int i = 0; i < NUM_FU; i++) exp_q[i].delete();
         rr_m      = 0;
         exp_valid = 1'b0;
         exp_tag   = '0;
         exp_v     = '0;
      end else begin
         if (g >= 0) begin
            ent       = exp_q[g].pop_front();
            exp_valid = 1'b1;
            exp_tag   = ent[ENT_W-1:XLEN];
            exp_v     = ent[XLEN-1:0];
            rr_m      = (g + 1) % NUM_FU;
         end else begin
            exp_valid = 1'b0;
            exp_tag   = '0;
            exp_v     = '0;
         end
         for (int i = 0; i < NUM_FU; i++) begin
            if (accepted[i] && fu_rob_tag[i] != '0) exp_q[i].push_back({fu_rob_tag[i], fu_value[i]});
         end
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (accepted[i]) void'(src_q[i].pop_front());
      end
      if (cdb_valid) seen_q.push_back(cdb_rob_tag);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset      = 1'b0;
      squash     = 1'b0;
      fu_valid   = '0;
      fu_rob_tag = '0;
      fu_value   = '0;
      rr_m       = 0;
      exp_valid  = 1'b0;
      exp_tag    = '0;
      exp_v      = '0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || cdb_v !== '0) begin
         errors++;
         $display("FAIL reset_cdb: got v=%0b tag=%0d val=%h, want 0/0/0", cdb_valid, cdb_rob_tag, cdb_v);
      end
      checks++;
      if (fu_ready !== 5'b11111) begin
         errors++;
         $display("FAIL reset_ready: got %b want 11111", fu_ready);
      end
      checks++;
      if (dbg_rr_ptr !== 3'd0) begin
         errors++;
         $display("FAIL reset_rr: got %0d want 0", dbg_rr_ptr);
      end
      reset = 1'b1;
   endtask

   task automatic test_single();
      src_q[0].push_back({5'd3, 32'hDEADBEEF});
      for (int c = 0; c < 3; c++) begin
         run_cycle();
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL single_model: got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
         if (c == 1) begin
            checks++;
            if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd3 || cdb_v !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL single_bcast: got v=%0b tag=%0d val=%h, want 1/3/deadbeef",
                        cdb_valid, cdb_rob_tag, cdb_v);
            end
         end
         if (c == 2) begin
            checks++;
            if (cdb_valid !== 1'b0 || cdb_rob_tag !== 5'd0) begin
               errors++;
               $display("FAIL single_hold: got v=%0b tag=%0d, want 0/0", cdb_valid, cdb_rob_tag);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      squash = 1'b1;
      run_cycle();
      squash = 1'b0;
      checks++;
      if (dbg_rr_ptr !== 3'd0) begin
         errors++;
         $display("FAIL rr_after_squash: got %0d want 0", dbg_rr_ptr);
      end
      seen_q.delete();
      src_q[0].push_back({5'd1, 32'h1111_0000});
      src_q[2].push_back({5'd2, 32'h2222_0000});
      src_q[4].push_back({5'd3, 32'h3333_0000});
      for (int c = 0; c < 5; c++) begin
         run_cycle();
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL rr_model: got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
         checks++;
         if (dbg_rr_ptr !== RR_W'(rr_m)) begin
            errors++;
            $display("FAIL rr_ptr: got %0d want %0d", dbg_rr_ptr, rr_m);
         end
      end
      checks++;
      if (seen_q.size() != 3 || seen_q[0] !== 5'd1 || seen_q[1] !== 5'd2 || seen_q[2] !== 5'd3) begin
         errors++;
         $display("FAIL rr_order: got %p want '{1,2,3}", seen_q);
      end
      checks++;
      if (dbg_rr_ptr !== 3'd0) begin
         errors++;
         $display("FAIL rr_final: got %0d want 0", dbg_rr_ptr);
      end
   endtask

   task automatic test_backpressure();
      logic             saw_full;
      logic [TAG_W-1:0] fu1_tags[$];
      saw_full = 1'b0;
      seen_q.delete();
      for (int t = 16; t < 24; t++) src_q[0].push_back({TAG_W'(t), XLEN'(t * 3)});
      for (int t = 5; t < 8; t++)   src_q[1].push_back({TAG_W'(t), XLEN'(t * 7)});
      for (int c = 0; c < 40 && pending() != 0; c++) begin
         run_cycle();
         if (ready_seen[1] === 1'b0) saw_full = 1'b1;
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL bp_model: got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
         checks++;
         if (ready_seen !== exp_ready) begin
            errors++;
            $display("FAIL bp_ready: got %b want %b", ready_seen, exp_ready);
         end
      end
      run_cycle();
      checks++;
      if (pending() != 0 || cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got %0d pending valid=%0b, want 0 pending valid=0", pending(), cdb_valid);
      end
      checks++;
      if (!saw_full) begin
         errors++;
         $display("FAIL bp_full: got fu_ready[1] never 0, want 0 once FU1 FIFO holds 2");
      end
      foreach (seen_q[i]) if (seen_q[i] >= 5 && seen_q[i] <= 7) fu1_tags.push_back(seen_q[i]);
      checks++;
      if (fu1_tags.size() != 3 || fu1_tags[0] !== 5'd5 || fu1_tags[1] !== 5'd6 || fu1_tags[2] !== 5'd7) begin
         errors++;
         $display("FAIL bp_order: got %p want '{5,6,7}", fu1_tags);
      end
   endtask

   task automatic test_squash();
      squash = 1'b1;
      run_cycle();
      squash = 1'b0;
      src_q[0].push_back({5'd20, 32'hA0});
      src_q[0].push_back({5'd21, 32'hA1});
      src_q[1].push_back({5'd22, 32'hB0});
      src_q[1].push_back({5'd23, 32'hB1});
      src_q[3].push_back({5'd8,  32'h8888});
      src_q[3].push_back({5'd9,  32'h9999});
      for (int c = 0; c < 2; c++) begin
         run_cycle();
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL sq_setup: got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
      end
      seen_q.delete();
      squash = 1'b1;
      src_q[2].push_back({5'd10, 32'h1010});
      run_cycle();
      squash = 1'b0;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || cdb_v !== '0) begin
         errors++;
         $display("FAIL sq_out: got v=%0b tag=%0d val=%h, want 0/0/0", cdb_valid, cdb_rob_tag, cdb_v);
      end
      checks++;
      if (fu_ready !== 5'b11111) begin
         errors++;
         $display("FAIL sq_ready: got %b want 11111", fu_ready);
      end
      for (int c = 0; c < 6; c++) begin
         run_cycle();
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL sq_model: got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
      end
      checks++;
      if (seen_q.size() != 0) begin
         errors++;
         $display("FAIL sq_leak: got %p broadcast after squash, want none", seen_q);
      end
   endtask

   task automatic test_zero_tag();
      seen_q.delete();
      src_q[4].push_back({5'd0, 32'h0000_1234});
      run_cycle();
      checks++;
      if (ready_seen[4] !== 1'b1) begin
         errors++;
         $display("FAIL zero_accept: got fu_ready[4]=%0b want 1", ready_seen[4]);
      end
      for (int c = 0; c < 2; c++) begin
         run_cycle();
         checks++;
         if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0) begin
            errors++;
            $display("FAIL zero_bcast: got v=%0b tag=%0d, want 0/0", cdb_valid, cdb_rob_tag);
         end
      end
      src_q[4].push_back({5'd12, 32'hCAFEF00D});
      for (int c = 0; c < 3; c++) begin
         run_cycle();
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL zero_model: got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
      end
      checks++;
      if (seen_q.size() != 1 || seen_q[0] !== 5'd12) begin
         errors++;
         $display("FAIL zero_follow: got %p want '{12}", seen_q);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < NUM_FU; i++) src_q[i].push_back({TAG_W'(i + 24), XLEN'(i)});
      run_cycle();
      run_cycle();
      seen_q.delete();
      reset = 1'b0;
      run_cycle();
      reset = 1'b1;
      checks++;
      if (cdb_valid !== 1'b0 || cdb_rob_tag !== '0 || cdb_v !== '0 || fu_ready !== 5'b11111 || dbg_rr_ptr !== 3'd0) begin
         errors++;
         $display("FAIL midreset: got v=%0b tag=%0d val=%h ready=%b rr=%0d, want 0/0/0/11111/0",
                  cdb_valid, cdb_rob_tag, cdb_v, fu_ready, dbg_rr_ptr);
      end
      for (int c = 0; c < 4; c++) run_cycle();
      checks++;
      if (seen_q.size() != 0) begin
         errors++;
         $display("FAIL midreset_leak: got %p want none", seen_q);
      end
   endtask

   task automatic test_random();
      logic [ENT_W-1:0] ent;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (src_q[i].size() == 0 && $urandom_range(0, 99) < 45) begin
               ent = {TAG_W'($urandom_range(1, 31)), XLEN'($urandom())};
               src_q[i].push_back(ent);
            end
         end
         squash = ($urandom_range(0, 39) == 0);
         run_cycle();
         squash = 1'b0;
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL rand_cdb: cycle %0d got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     c, cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
         checks++;
         if (ready_seen !== exp_ready || dbg_rr_ptr !== RR_W'(rr_m)) begin
            errors++;
            $display("FAIL rand_state: cycle %0d got ready=%b rr=%0d, want ready=%b rr=%0d",
                     c, ready_seen, dbg_rr_ptr, exp_ready, rr_m);
         end
      end
      for (int c = 0; c < 60 && pending() != 0; c++) begin
         run_cycle();
         checks++;
         if ({cdb_valid, cdb_rob_tag, cdb_v} !== {exp_valid, exp_tag, exp_v}) begin
            errors++;
            $display("FAIL rand_drain: got v=%0b tag=%0d val=%h, want v=%0b tag=%0d val=%h",
                     cdb_valid, cdb_rob_tag, cdb_v, exp_valid, exp_tag, exp_v);
         end
      end
      checks++;
      if (pending() != 0) begin
         errors++;
         $display("FAIL rand_timeout: got %0d results still pending, want 0", pending());
      end
   endtask

   // ---------------- sequence + final report ----------------
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_squash();
      test_zero_tag();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
